// File: rtl/axi_lite_dmem_arb.sv
// Two-requester AXI4-Lite arbiter sharing one data memory; write and read paths arbitrate independently.
// Define AXIL_ARB_RR_EN for round-robin arbitration; otherwise port 0 always wins.
module axi_lite_dmem_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [1:0]              s_axil_awvalid,
    output logic [1:0]              s_axil_awready,
    input  logic [2*DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [2*STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic [1:0]              s_axil_wvalid,
    output logic [1:0]              s_axil_wready,
    output logic [3:0]              s_axil_bresp,
    output logic [1:0]              s_axil_bvalid,
    input  logic [1:0]              s_axil_bready,
    input  logic [2*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [1:0]              s_axil_arvalid,
    output logic [1:0]              s_axil_arready,
    output logic [2*DATA_WIDTH-1:0] s_axil_rdata,
    output logic [3:0]              s_axil_rresp,
    output logic [1:0]              s_axil_rvalid,
    input  logic [1:0]              s_axil_rready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_FWD = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FWD = 2'd1, R_RESP = 2'd2} r_state_t;

    w_state_t   r_wstate;
    r_state_t   r_rstate;
    logic       r_wgrant;
    logic       r_rgrant;
    logic       r_awvalid;
    logic       r_wvalid;
    logic       r_arvalid;

    logic [1:0] w_wreq;
    logic [1:0] w_rreq;
    logic       w_wpick;
    logic       w_rpick;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_ar_hs;
    logic       w_bready_sel;
    logic       w_rready_sel;
    logic       w_b_fwd;
    logic       w_r_fwd;
    logic       w_b_hs;
    logic       w_r_hs;

    assign w_wreq = s_axil_awvalid & s_axil_wvalid;
    assign w_rreq = s_axil_arvalid;

`ifdef AXIL_ARB_RR_EN
    logic r_wptr;
    logic r_rptr;

    // Round-robin choice: the pointer's preferred port wins when both request.
    always_comb begin
        w_wpick = 1'b0;
        w_rpick = 1'b0;
        if (r_wptr && w_wreq[1]) begin
            w_wpick = 1'b1;
        end else if (w_wreq[0]) begin
            w_wpick = 1'b0;
        end else begin
            w_wpick = 1'b1;
        end
        if (r_rptr && w_rreq[1]) begin
            w_rpick = 1'b1;
        end else if (w_rreq[0]) begin
            w_rpick = 1'b0;
        end else begin
            w_rpick = 1'b1;
        end
    end
`else
    // Fixed priority choice: port 0 wins whenever it requests.
    always_comb begin
        w_wpick = 1'b0;
        w_rpick = 1'b0;
        if (w_wreq[0]) begin
            w_wpick = 1'b0;
        end else begin
            w_wpick = 1'b1;
        end
        if (w_rreq[0]) begin
            w_rpick = 1'b0;
        end else begin
            w_rpick = 1'b1;
        end
    end
`endif

    // Valids are registered and live only in FWD, so handshakes need no extra state gating.
    assign w_aw_hs = r_awvalid & m_axil_awready;
    assign w_w_hs  = r_wvalid  & m_axil_wready;
    assign w_ar_hs = r_arvalid & m_axil_arready;

    assign w_bready_sel = r_wgrant ? s_axil_bready[1] : s_axil_bready[0];
    assign w_rready_sel = r_rgrant ? s_axil_rready[1] : s_axil_rready[0];
    assign w_b_fwd      = (r_wstate == W_RESP) & m_axil_bvalid;
    assign w_r_fwd      = (r_rstate == R_RESP) & m_axil_rvalid;
    assign w_b_hs       = w_b_fwd & w_bready_sel;
    assign w_r_hs       = w_r_fwd & w_rready_sel;

    assign m_axil_awaddr  = r_wgrant ? s_axil_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axil_awaddr[ADDR_WIDTH-1:0];
    assign m_axil_wdata   = r_wgrant ? s_axil_wdata[2*DATA_WIDTH-1:DATA_WIDTH]  : s_axil_wdata[DATA_WIDTH-1:0];
    assign m_axil_wstrb   = r_wgrant ? s_axil_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]  : s_axil_wstrb[STRB_WIDTH-1:0];
    assign m_axil_araddr  = r_rgrant ? s_axil_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axil_araddr[ADDR_WIDTH-1:0];
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_bready  = (r_wstate == W_RESP) & w_bready_sel;
    assign m_axil_rready  = (r_rstate == R_RESP) & w_rready_sel;

    assign s_axil_awready = {r_wgrant & w_aw_hs, ~r_wgrant & w_aw_hs};
    assign s_axil_wready  = {r_wgrant & w_w_hs,  ~r_wgrant & w_w_hs};
    assign s_axil_arready = {r_rgrant & w_ar_hs, ~r_rgrant & w_ar_hs};
    assign s_axil_bvalid  = {r_wgrant & w_b_fwd, ~r_wgrant & w_b_fwd};
    assign s_axil_rvalid  = {r_rgrant & w_r_fwd, ~r_rgrant & w_r_fwd};
    assign s_axil_bresp   = r_wgrant ? {m_axil_bresp, 2'b00} : {2'b00, m_axil_bresp};
    assign s_axil_rresp   = r_rgrant ? {m_axil_rresp, 2'b00} : {2'b00, m_axil_rresp};
    assign s_axil_rdata   = r_rgrant ? {m_axil_rdata, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, m_axil_rdata};

    // Write path FSM: grant, forward AW and W independently, then hold grant through B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_wgrant  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
`ifdef AXIL_ARB_RR_EN
            r_wptr    <= 1'b0;
`endif
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (|w_wreq) begin
                        r_wgrant  <= w_wpick;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wstate  <= W_FWD;
                    end
                end
                W_FWD: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if ((w_aw_hs || !r_awvalid) && (w_w_hs || !r_wvalid)) r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_wstate <= W_IDLE;
`ifdef AXIL_ARB_RR_EN
                        r_wptr   <= ~r_wgrant;
`endif
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read path FSM: grant, forward AR, then hold grant through R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_rgrant  <= 1'b0;
            r_arvalid <= 1'b0;
`ifdef AXIL_ARB_RR_EN
            r_rptr    <= 1'b0;
`endif
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (|w_rreq) begin
                        r_rgrant  <= w_rpick;
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_FWD;
                    end
                end
                R_FWD: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rstate  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (w_r_hs) begin
                        r_rstate <= R_IDLE;
`ifdef AXIL_ARB_RR_EN
                        r_rptr   <= ~r_rgrant;
`endif
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_dmem_arb.sv
// Self-checking bench for axi_lite_dmem_arb: memory slave, two requester tasks and a reference model.
module tb_axi_lite_dmem_arb;

`ifdef AXIL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_awaddr, s_araddr;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_wdata, s_rdata;
    logic [7:0]  s_wstrb;
    logic [3:0]  s_bresp, s_rresp;
    logic [15:0] m_awaddr, m_araddr;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    logic [15:0] awaddr_p[2], araddr_p[2];
    logic [31:0] wdata_p[2];
    logic [3:0]  wstrb_p[2];
    logic        awvalid_p[2], wvalid_p[2], bready_p[2], arvalid_p[2], rready_p[2];

    assign s_awaddr  = {awaddr_p[1], awaddr_p[0]};
    assign s_araddr  = {araddr_p[1], araddr_p[0]};
    assign s_wdata   = {wdata_p[1], wdata_p[0]};
    assign s_wstrb   = {wstrb_p[1], wstrb_p[0]};
    assign s_awvalid = {awvalid_p[1], awvalid_p[0]};
    assign s_wvalid  = {wvalid_p[1], wvalid_p[0]};
    assign s_bready  = {bready_p[1], bready_p[0]};
    assign s_arvalid = {arvalid_p[1], arvalid_p[0]};
    assign s_rready  = {rready_p[1], rready_p[0]};

    axi_lite_dmem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
        .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
        .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
        .s_axil_araddr(s_araddr), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
        .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
        .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .m_axil_araddr(m_araddr), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory slave: addresses with bit 15 set answer SLVERR and store nothing.
    logic [31:0] mem [0:1023];
    logic [3:0]  rnd;
    logic        hold_rdy = 1'b0, fast = 1'b0;
    logic        aw_got, w_got, sb_valid, ar_got, sr_valid;
    logic [15:0] aw_a, ar_a;
    logic [31:0] w_d, sr_data;
    logic [3:0]  w_s;
    logic [1:0]  sb_resp, sr_resp;
    int          cyc_now = 0;

    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    always @(posedge clk) rnd <= 4'($urandom);
    always @(posedge clk) cyc_now <= cyc_now + 1;

    assign m_awready = !aw_got && !hold_rdy && (fast || rnd[0]);
    assign m_wready  = !w_got && !hold_rdy && (fast || rnd[1]);
    assign m_arready = !ar_got && !sr_valid && !hold_rdy && (fast || rnd[2]);
    assign m_bvalid  = sb_valid;
    assign m_bresp   = sb_resp;
    assign m_rvalid  = sr_valid;
    assign m_rresp   = sr_resp;
    assign m_rdata   = sr_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; sb_valid <= 1'b0; ar_got <= 1'b0; sr_valid <= 1'b0;
            sb_resp <= 2'b00; sr_resp <= 2'b00; sr_data <= 32'h0;
        end else begin
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
            if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
            if (aw_got && w_got && !sb_valid) begin
                if (!aw_a[15]) mem[aw_a[11:2]] <= merge(mem[aw_a[11:2]], w_d, w_s);
                sb_resp <= aw_a[15] ? 2'b10 : 2'b00;
                sb_valid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (sb_valid && m_bready) sb_valid <= 1'b0;
            if (m_arvalid && m_arready) begin ar_got <= 1'b1; ar_a <= m_araddr; end
            if (ar_got) begin
                sr_valid <= 1'b1; ar_got <= 1'b0;
                sr_data  <= ar_a[15] ? 32'h0 : mem[ar_a[11:2]];
                sr_resp  <= ar_a[15] ? 2'b10 : 2'b00;
            end
            if (sr_valid && m_rready) sr_valid <= 1'b0;
        end
    end

    // Reference model: expected memory image and arbitration pointers.
    logic [31:0] ref_mem [0:1023];
    int ref_wptr = 0, ref_rptr = 0;
    int wr_order[$], rd_order[$];
    int wr_done_cyc[2], rd_done_cyc[2];
    int n_cmp = 0, n_fail = 0;

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        return a[15] ? 32'h0 : ref_mem[a[11:2]];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_wr(input int p, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input int stall);
        bit aw_hs, w_hs, b_hs, bv, done, stalling;
        int cyc, left;
        done = 0; stalling = 0; cyc = 0; left = stall;
        @(posedge clk); #1;
        awaddr_p[p] = a; wdata_p[p] = d; wstrb_p[p] = s;
        awvalid_p[p] = 1'b1; wvalid_p[p] = 1'b1; bready_p[p] = (stall == 0);
        while (!done && cyc < 500) begin
            @(negedge clk);
            aw_hs = awvalid_p[p] && s_awready[p];
            w_hs  = wvalid_p[p] && s_wready[p];
            bv    = s_bvalid[p];
            b_hs  = bv && bready_p[p];
            if (bv) check("bvalid_excl", {63'h0, s_bvalid[1-p]}, 64'h0);
            if (stalling && !bready_p[p]) begin
                check("bvalid_hold", {63'h0, s_bvalid[p]}, 64'h1);
                check("aw_stalled", {63'h0, m_awvalid}, 64'h0);
            end
            if (b_hs) check("bresp", {62'h0, s_bresp[2*p +: 2]}, a[15] ? 64'h2 : 64'h0);
            @(posedge clk); #1; cyc++;
            if (aw_hs) awvalid_p[p] = 1'b0;
            if (w_hs) wvalid_p[p] = 1'b0;
            if (bv && !bready_p[p]) stalling = 1;
            if (stalling && !bready_p[p]) begin
                left--;
                if (left <= 0) bready_p[p] = 1'b1;
            end
            if (b_hs) begin
                done = 1; bready_p[p] = 1'b0;
                if (!a[15]) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, s);
                ref_wptr = 1 - p;
                wr_order.push_back(p);
                wr_done_cyc[p] = cyc_now;
            end
        end
        if (!done) check("wr_timeout", 64'h0, 64'h1);
    endtask

    task automatic do_rd(input int p, input logic [15:0] base, input int n, output logic [31:0] last);
        bit ar_hs, r_hs;
        int k, cyc;
        logic [15:0] a;
        k = 0; cyc = 0; a = base; last = 32'h0;
        @(posedge clk); #1;
        araddr_p[p] = a; arvalid_p[p] = 1'b1; rready_p[p] = 1'b1;
        while (k < n && cyc < 1000) begin
            @(negedge clk);
            ar_hs = arvalid_p[p] && s_arready[p];
            r_hs  = rready_p[p] && s_rvalid[p];
            if (s_rvalid[p]) check("rvalid_excl", {63'h0, s_rvalid[1-p]}, 64'h0);
            if (r_hs) begin
                check("rdata", {32'h0, s_rdata[32*p +: 32]}, {32'h0, ref_read(a)});
                check("rresp", {62'h0, s_rresp[2*p +: 2]}, a[15] ? 64'h2 : 64'h0);
                last = s_rdata[32*p +: 32];
            end
            @(posedge clk); #1; cyc++;
            if (ar_hs) arvalid_p[p] = 1'b0;
            if (r_hs) begin
                rd_order.push_back(p); ref_rptr = 1 - p; rd_done_cyc[p] = cyc_now; k++;
                if (k < n) begin
                    a = a + 16'h4; araddr_p[p] = a; arvalid_p[p] = 1'b1;
                end else begin
                    rready_p[p] = 1'b0;
                end
            end
        end
        if (k < n) check("rd_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        logic [31:0] rd, d;
        logic [15:0] a, a2;
        logic [3:0]  s;
        int p, p2, exp_first, rem0, rem1, ptr, w;
        int exp_q[$];

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            awaddr_p[i] = 16'h0; araddr_p[i] = 16'h0; wdata_p[i] = 32'h0; wstrb_p[i] = 4'h0;
            awvalid_p[i] = 1'b0; wvalid_p[i] = 1'b0; bready_p[i] = 1'b0; arvalid_p[i] = 1'b0; rready_p[i] = 1'b0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", {56'h0, s_awready, s_wready, s_arready, 2'b00}, 64'h0);
        check("rst_s_valid", {60'h0, s_bvalid, s_rvalid}, 64'h0);
        check("rst_m_ctrl", {59'h0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // simultaneous writes
        wr_order.delete();
        exp_first = RR ? ref_wptr : 0;
        fork
            do_wr(0, 16'h0020, 32'h11111111, 4'hF, 0);
            do_wr(1, 16'h0024, 32'h22222222, 4'hF, 0);
        join
        check("sim_wr_first", 64'(wr_order[0]), 64'(exp_first));
        check("sim_wr_second", 64'(wr_order[1]), 64'(1 - exp_first));
        check("sim_wr_bvalid_order", {63'h0, wr_done_cyc[exp_first] < wr_done_cyc[1 - exp_first]}, 64'h1);
        do_rd(0, 16'h0020, 2, rd);
        check("readback_0024", {32'h0, rd}, 64'h22222222);

        // single write then read from the other port
        do_wr(0, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
        do_rd(1, 16'h0010, 1, rd);
        check("wr0_rd1", {32'h0, rd}, 64'hDEADBEEF);

        // both ports stream 4 reads each
        rd_order.delete(); exp_q.delete();
        rem0 = 4; rem1 = 4; ptr = ref_rptr;
        for (int i = 0; i < 8; i++) begin
            if (rem0 > 0 && rem1 > 0) w = RR ? ptr : 0;
            else w = (rem0 > 0) ? 0 : 1;
            exp_q.push_back(w);
            if (w == 0) rem0--; else rem1--;
            ptr = 1 - w;
        end
        fork
            do_rd(0, 16'h0020, 4, rd);
            do_rd(1, 16'h0020, 4, d);
        join
        for (int i = 0; i < 8; i++) check("rd_grant_order", 64'(rd_order[i]), 64'(exp_q[i]));

        // partial strobe merge
        do_wr(1, 16'h0030, 32'hFFFFFFFF, 4'hF, 0);
        do_wr(0, 16'h0030, 32'hAAAABBBB, 4'h3, 0);
        do_rd(0, 16'h0030, 1, rd);
        check("strb_merge", {32'h0, rd}, 64'hFFFFBBBB);

        // port 1 stalls B; port 0 write waits, port 0 read proceeds
        fast = 1'b1;
        wr_order.delete();
        fork
            do_wr(1, 16'h0040, 32'h40404040, 4'hF, 5);
            begin
                @(posedge clk);
                fork
                    do_wr(0, 16'h0044, 32'h44444444, 4'hF, 0);
                    do_rd(0, 16'h0010, 1, rd);
                join
            end
        join
        fast = 1'b0;
        check("stall_wr_first", 64'(wr_order[0]), 64'h1);
        check("stall_wr_second", 64'(wr_order[1]), 64'h0);
        check("stall_parallel_rd", {63'h0, rd_done_cyc[0] < wr_done_cyc[1]}, 64'h1);
        check("stall_rd_data", {32'h0, rd}, 64'hDEADBEEF);

        // randomized sequential traffic
        for (int i = 0; i < 30; i++) begin
            p = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) a = 16'h8100 + 16'(4 * $urandom_range(0, 3));
            else a = 16'h0100 + 16'(4 * $urandom_range(0, 7));
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) do_wr(p, a, d, s, 0);
            else do_rd(p, a, 1, rd);
        end

        // randomized concurrent write + read
        for (int i = 0; i < 8; i++) begin
            p  = $urandom_range(0, 1);
            p2 = $urandom_range(0, 1);
            a  = 16'h0200 + 16'(4 * $urandom_range(0, 7));
            a2 = 16'h0100 + 16'(4 * $urandom_range(0, 7));
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            fork
                do_wr(p, a, d, s, 0);
                do_rd(p2, a2, 1, rd);
            join
        end
        do_rd(1, 16'h0200, 8, rd);

        // reset while in R_FWD, plus arbitration latency
        @(posedge clk); #1;
        hold_rdy = 1'b1;
        araddr_p[0] = 16'h0010; arvalid_p[0] = 1'b1; rready_p[0] = 1'b1;
        @(negedge clk);
        check("lat_idle", {63'h0, m_arvalid}, 64'h0);
        @(negedge clk);
        check("lat_next", {63'h0, m_arvalid}, 64'h1);
        check("lat_addr", {48'h0, m_araddr}, 64'h0010);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_m", {59'h0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 64'h0);
        check("rst_mid_s", {54'h0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 64'h0);
        arvalid_p[0] = 1'b0; rready_p[0] = 1'b0; hold_rdy = 1'b0;
        ref_wptr = 0; ref_rptr = 0;
        @(negedge clk); rst_n = 1'b1;
        do_rd(0, 16'h0010, 1, rd);
        check("post_rst_rd", {32'h0, rd}, 64'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
